// File: rtl/cpu_pkg.sv
// Shared types and constants for the basic processor control path.
// Opcode and sequencer state encodings live here so datapath and control agree.
package cpu_pkg;

    localparam int OP_W   = 3;
    localparam int WORD_W = 8;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_STORE = 3'b001,
        OP_ADD   = 3'b010,
        OP_DEC   = 3'b011,
        OP_LSH   = 3'b100,
        OP_RSH   = 3'b101,
        OP_MOD2  = 3'b110,
        OP_BNE   = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_F_PC  = 3'd1,
        S_F_RD  = 3'd2,
        S_F_AD  = 3'd3,
        S_EX    = 3'd4,
        S_ST_WR = 3'd5
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute control FSM driving the accumulator ALU, PC, IR/MAR/MDR
// and memory strobes. Outputs are decoded combinationally from state and inputs.
module alu_sequencer
    import cpu_pkg::*;
#(
    parameter int OP_W = 3
) (
    input  logic            clock,
    input  logic            n_reset,
    input  logic            run,
    input  logic [OP_W-1:0] op,
    input  logic            z_flag,
    input  logic            mem_ready,
    output logic            ACC_bus,
    output logic            load_ACC,
    output logic            ALU_ACC,
    output logic            ALU_add,
    output logic            ALU_sub,
    output logic            ALU_lshift,
    output logic            ALU_rshift,
    output logic            ALU_mod2,
    output logic            PC_bus,
    output logic            load_PC,
    output logic            INC_PC,
    output logic            Addr_bus,
    output logic            load_IR,
    output logic            load_MAR,
    output logic            MDR_bus,
    output logic            load_MDR,
    output logic            CS,
    output logic            R_NW,
    output logic            halted
);

    seq_state_t state_reg;
    seq_state_t state_next;
    op_t        op_dec;

    assign op_dec = op_t'(op);

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ACC_bus    = 1'b0;
        load_ACC   = 1'b0;
        ALU_ACC    = 1'b0;
        ALU_add    = 1'b0;
        ALU_sub    = 1'b0;
        ALU_lshift = 1'b0;
        ALU_rshift = 1'b0;
        ALU_mod2   = 1'b0;
        PC_bus     = 1'b0;
        load_PC    = 1'b0;
        INC_PC     = 1'b0;
        Addr_bus   = 1'b0;
        load_IR    = 1'b0;
        load_MAR   = 1'b0;
        MDR_bus    = 1'b0;
        load_MDR   = 1'b0;
        CS         = 1'b0;
        R_NW       = 1'b1;
        halted     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                halted = 1'b1;
                if (run) state_next = S_F_PC;
            end
            S_F_PC: begin
                PC_bus     = 1'b1;
                load_MAR   = 1'b1;
                INC_PC     = 1'b1;
                state_next = S_F_RD;
            end
            S_F_RD: begin
                CS = 1'b1;
                if (mem_ready) begin
                    load_IR    = 1'b1;
                    state_next = S_F_AD;
                end
            end
            S_F_AD: begin
                Addr_bus   = 1'b1;
                load_MAR   = 1'b1;
                state_next = S_EX;
            end
            S_EX: begin
                // Register-only ops complete in one cycle; memory ops hold until ready.
                case (op_dec)
                    OP_LOAD: begin
                        CS = 1'b1;
                        if (mem_ready) begin
                            load_ACC   = 1'b1;
                            state_next = S_F_PC;
                        end
                    end
                    OP_STORE: begin
                        ACC_bus    = 1'b1;
                        load_MDR   = 1'b1;
                        state_next = S_ST_WR;
                    end
                    OP_ADD: begin
                        CS = 1'b1;
                        if (mem_ready) begin
                            load_ACC   = 1'b1;
                            ALU_ACC    = 1'b1;
                            ALU_add    = 1'b1;
                            state_next = S_F_PC;
                        end
                    end
                    OP_DEC: begin
                        load_ACC   = 1'b1;
                        ALU_ACC    = 1'b1;
                        ALU_sub    = 1'b1;
                        state_next = S_F_PC;
                    end
                    OP_LSH: begin
                        load_ACC   = 1'b1;
                        ALU_ACC    = 1'b1;
                        ALU_lshift = 1'b1;
                        state_next = S_F_PC;
                    end
                    OP_RSH: begin
                        load_ACC   = 1'b1;
                        ALU_ACC    = 1'b1;
                        ALU_rshift = 1'b1;
                        state_next = S_F_PC;
                    end
                    OP_MOD2: begin
                        load_ACC   = 1'b1;
                        ALU_mod2   = 1'b1;
                        state_next = S_F_PC;
                    end
                    OP_BNE: begin
                        if (!z_flag) begin
                            Addr_bus = 1'b1;
                            load_PC  = 1'b1;
                        end
                        state_next = S_F_PC;
                    end
                    default: state_next = S_F_PC;
                endcase
            end
            S_ST_WR: begin
                CS      = 1'b1;
                R_NW    = 1'b0;
                MDR_bus = 1'b1;
                if (mem_ready) state_next = S_F_PC;
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: walks each instruction class through
// fetch/execute and compares the full strobe vector every cycle.
module tb_alu_sequencer;

    logic       clock;
    logic       n_reset;
    logic       run;
    logic [2:0] op;
    logic       z_flag;
    logic       mem_ready;
    logic ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_lshift, ALU_rshift, ALU_mod2;
    logic PC_bus, load_PC, INC_PC, Addr_bus, load_IR, load_MAR, MDR_bus, load_MDR;
    logic CS, R_NW, halted;

    int compared;
    int mismatched;

    // Strobe vector bit masks
    localparam logic [18:0] M_ACC_BUS  = 19'h40000;
    localparam logic [18:0] M_LD_ACC   = 19'h20000;
    localparam logic [18:0] M_ALU_ACC  = 19'h10000;
    localparam logic [18:0] M_ADD      = 19'h08000;
    localparam logic [18:0] M_SUB      = 19'h04000;
    localparam logic [18:0] M_LSH      = 19'h02000;
    localparam logic [18:0] M_RSH      = 19'h01000;
    localparam logic [18:0] M_MOD2     = 19'h00800;
    localparam logic [18:0] M_PC_BUS   = 19'h00400;
    localparam logic [18:0] M_LD_PC    = 19'h00200;
    localparam logic [18:0] M_INC_PC   = 19'h00100;
    localparam logic [18:0] M_ADDR_BUS = 19'h00080;
    localparam logic [18:0] M_LD_IR    = 19'h00040;
    localparam logic [18:0] M_LD_MAR   = 19'h00020;
    localparam logic [18:0] M_MDR_BUS  = 19'h00010;
    localparam logic [18:0] M_LD_MDR   = 19'h00008;
    localparam logic [18:0] M_CS       = 19'h00004;
    localparam logic [18:0] M_RNW      = 19'h00002;
    localparam logic [18:0] M_HALT     = 19'h00001;

    localparam logic [18:0] V_IDLE = M_HALT | M_RNW;
    localparam logic [18:0] V_F_PC = M_PC_BUS | M_LD_MAR | M_INC_PC | M_RNW;
    localparam logic [18:0] V_F_AD = M_ADDR_BUS | M_LD_MAR | M_RNW;

    logic [18:0] obs;
    assign obs = {ACC_bus, load_ACC, ALU_ACC, ALU_add, ALU_sub, ALU_lshift, ALU_rshift,
                  ALU_mod2, PC_bus, load_PC, INC_PC, Addr_bus, load_IR, load_MAR,
                  MDR_bus, load_MDR, CS, R_NW, halted};

    alu_sequencer #(.OP_W(3)) dut (
        .clock(clock), .n_reset(n_reset), .run(run), .op(op), .z_flag(z_flag),
        .mem_ready(mem_ready),
        .ACC_bus(ACC_bus), .load_ACC(load_ACC), .ALU_ACC(ALU_ACC), .ALU_add(ALU_add),
        .ALU_sub(ALU_sub), .ALU_lshift(ALU_lshift), .ALU_rshift(ALU_rshift),
        .ALU_mod2(ALU_mod2), .PC_bus(PC_bus), .load_PC(load_PC), .INC_PC(INC_PC),
        .Addr_bus(Addr_bus), .load_IR(load_IR), .load_MAR(load_MAR), .MDR_bus(MDR_bus),
        .load_MDR(load_MDR), .CS(CS), .R_NW(R_NW), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; inputs are then changed 1ns after the edge and
    // outputs sampled 1ns after that.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Starts in F_PC, ends in EX. Optional wait cycles in F_RD.
    task automatic do_fetch(input logic [2:0] opc, input int rd_wait, input string tag);
        op = opc;
        mem_ready = 1'b1;
        settle();
        compared++;
        if (obs !== V_F_PC) begin
            mismatched++;
            $display("FAIL %s_f_pc: got %b expected %b", tag, obs, V_F_PC);
        end
        step();
        for (int i = 0; i < rd_wait; i++) begin
            mem_ready = 1'b0;
            settle();
            compared++;
            if (obs !== (M_CS | M_RNW)) begin
                mismatched++;
                $display("FAIL %s_f_rd_wait%0d: got %b expected %b", tag, i, obs, M_CS | M_RNW);
            end
            step();
        end
        mem_ready = 1'b1;
        settle();
        compared++;
        if (obs !== (M_CS | M_RNW | M_LD_IR)) begin
            mismatched++;
            $display("FAIL %s_f_rd: got %b expected %b", tag, obs, M_CS | M_RNW | M_LD_IR);
        end
        step();
        settle();
        compared++;
        if (obs !== V_F_AD) begin
            mismatched++;
            $display("FAIL %s_f_ad: got %b expected %b", tag, obs, V_F_AD);
        end
        step();
    endtask

    task automatic test_reset();
        n_reset = 1'b0; run = 1'b0; op = 3'b000; z_flag = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clock);
        #3 n_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            compared++;
            if (obs !== V_IDLE) begin
                mismatched++;
                $display("FAIL reset_idle%0d: got %b expected %b", i, obs, V_IDLE);
            end
        end
        run = 1'b1;
        step();
        run = 1'b0;
        settle();
        compared++;
        if (obs !== V_F_PC) begin
            mismatched++;
            $display("FAIL reset_run_f_pc: got %b expected %b", obs, V_F_PC);
        end
        $display("txn reset: idle x5 then run -> F_PC");
    endtask

    task automatic test_dec();
        do_fetch(3'b011, 0, "dec");
        settle();
        compared++;
        if (obs !== (M_LD_ACC | M_ALU_ACC | M_SUB | M_RNW)) begin
            mismatched++;
            $display("FAIL dec_ex: got %b expected %b", obs, M_LD_ACC | M_ALU_ACC | M_SUB | M_RNW);
        end
        step();
        settle();
        compared++;
        if (obs !== V_F_PC) begin
            mismatched++;
            $display("FAIL dec_return: got %b expected %b", obs, V_F_PC);
        end
        $display("txn DEC: 4 cycles");
    endtask

    task automatic test_add_wait();
        do_fetch(3'b010, 0, "add");
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0;
            settle();
            compared++;
            if (obs !== (M_CS | M_RNW)) begin
                mismatched++;
                $display("FAIL add_wait%0d: got %b expected %b", i, obs, M_CS | M_RNW);
            end
            step();
        end
        mem_ready = 1'b1;
        settle();
        compared++;
        if (obs !== (M_CS | M_RNW | M_LD_ACC | M_ALU_ACC | M_ADD)) begin
            mismatched++;
            $display("FAIL add_ex: got %b expected %b", obs,
                     M_CS | M_RNW | M_LD_ACC | M_ALU_ACC | M_ADD);
        end
        step();
        settle();
        compared++;
        if (obs !== V_F_PC) begin
            mismatched++;
            $display("FAIL add_return: got %b expected %b", obs, V_F_PC);
        end
        $display("txn ADD: 3 wait cycles, 7 cycles total");
    endtask

    // Remaining one-cycle-execute ops plus LOAD; one of them waits in F_RD.
    task automatic test_other_ops();
        logic [2:0]  ops [4]    = '{3'b100, 3'b101, 3'b110, 3'b000};
        logic [18:0] ex_exp [4] = '{M_LD_ACC | M_ALU_ACC | M_LSH | M_RNW,
                                    M_LD_ACC | M_ALU_ACC | M_RSH | M_RNW,
                                    M_LD_ACC | M_MOD2 | M_RNW,
                                    M_LD_ACC | M_CS | M_RNW};
        for (int k = 0; k < 4; k++) begin
            do_fetch(ops[k], (k == 1) ? 2 : 0, "op");
            if (ops[k] == 3'b000) begin
                mem_ready = 1'b0;
                settle();
                compared++;
                if (obs !== (M_CS | M_RNW)) begin
                    mismatched++;
                    $display("FAIL load_wait: got %b expected %b", obs, M_CS | M_RNW);
                end
                step();
                mem_ready = 1'b1;
            end
            settle();
            compared++;
            if (obs !== ex_exp[k]) begin
                mismatched++;
                $display("FAIL op%0d_ex: got %b expected %b", ops[k], obs, ex_exp[k]);
            end
            step();
            $display("txn op=%03b executed", ops[k]);
        end
    endtask

    task automatic test_store();
        do_fetch(3'b001, 0, "st");
        settle();
        compared++;
        if (obs !== (M_ACC_BUS | M_LD_MDR | M_RNW)) begin
            mismatched++;
            $display("FAIL st_ex: got %b expected %b", obs, M_ACC_BUS | M_LD_MDR | M_RNW);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2);
            settle();
            compared++;
            if (obs !== (M_CS | M_MDR_BUS)) begin
                mismatched++;
                $display("FAIL st_wr%0d: got %b expected %b", i, obs, M_CS | M_MDR_BUS);
            end
            step();
        end
        mem_ready = 1'b1;
        settle();
        compared++;
        if (obs !== V_F_PC) begin
            mismatched++;
            $display("FAIL st_return: got %b expected %b", obs, V_F_PC);
        end
        $display("txn STORE: 2 write wait cycles");
    endtask

    task automatic test_bne();
        for (int z = 0; z < 2; z++) begin
            do_fetch(3'b111, 0, "bne");
            z_flag = z[0];
            settle();
            compared++;
            if (obs !== ((z == 0) ? (M_ADDR_BUS | M_LD_PC | M_RNW) : M_RNW)) begin
                mismatched++;
                $display("FAIL bne_z%0d_ex: got %b expected %b", z, obs,
                         (z == 0) ? (M_ADDR_BUS | M_LD_PC | M_RNW) : M_RNW);
            end
            step();
            z_flag = 1'b0;
            settle();
            compared++;
            if (obs !== V_F_PC) begin
                mismatched++;
                $display("FAIL bne_z%0d_return: got %b expected %b", z, obs, V_F_PC);
            end
            $display("txn BNE z_flag=%0d", z);
        end
    endtask

    task automatic test_reset_mid_op();
        do_fetch(3'b001, 0, "rst");
        step();
        mem_ready = 1'b0;
        settle();
        compared++;
        if (obs !== (M_CS | M_MDR_BUS)) begin
            mismatched++;
            $display("FAIL rst_st_wr: got %b expected %b", obs, M_CS | M_MDR_BUS);
        end
        #2 n_reset = 1'b0;
        #1;
        compared++;
        if (obs !== V_IDLE) begin
            mismatched++;
            $display("FAIL rst_async: got %b expected %b", obs, V_IDLE);
        end
        step();
        n_reset = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            compared++;
            if (obs !== V_IDLE) begin
                mismatched++;
                $display("FAIL rst_after%0d: got %b expected %b", i, obs, V_IDLE);
            end
        end
        $display("txn reset during ST_WR -> IDLE");
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset();
        test_dec();
        test_add_wait();
        test_other_ops();
        test_store();
        test_bne();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
